// File: rtl/pcs_tx_pkg.sv
// Shared 4B/5B PCS definitions: code widths, control code groups and the
// transmit state enumeration (also used by the receive PCS).
package pcs_tx_pkg;

    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned CODE_W   = 5;
    localparam int unsigned PHASE_W  = 3;

    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(4);

    typedef logic [CODE_W-1:0] code_t;

    localparam code_t CODE_I = 5'b11111;
    localparam code_t CODE_J = 5'b11000;
    localparam code_t CODE_K = 5'b10001;
    localparam code_t CODE_T = 5'b01101;
    localparam code_t CODE_R = 5'b00111;
    localparam code_t CODE_H = 5'b00100;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START_K = 2'd1,
        DATA    = 2'd2,
        END_R   = 2'd3
    } pcs_state_e;

    // One MII transmit sample as seen on a consume strobe.
    typedef struct packed {
        logic                en;
        logic                er;
        logic [NIBBLE_W-1:0] d;
    } mii_tx_t;

endpackage

// File: rtl/encode_4b5b.sv
// Combinational 4B-to-5B data code mapping.
module encode_4b5b
    import pcs_tx_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble_i,
    output code_t               code_o
);

    always_comb begin
        code_o = CODE_I;
        case (nibble_i)
            4'h0: code_o = 5'b11110;
            4'h1: code_o = 5'b01001;
            4'h2: code_o = 5'b10100;
            4'h3: code_o = 5'b10101;
            4'h4: code_o = 5'b01010;
            4'h5: code_o = 5'b01011;
            4'h6: code_o = 5'b01110;
            4'h7: code_o = 5'b01111;
            4'h8: code_o = 5'b10010;
            4'h9: code_o = 5'b10011;
            4'hA: code_o = 5'b10110;
            4'hB: code_o = 5'b10111;
            4'hC: code_o = 5'b11010;
            4'hD: code_o = 5'b11011;
            4'hE: code_o = 5'b11100;
            4'hF: code_o = 5'b11101;
            default: code_o = CODE_I;
        endcase
    end

endmodule

// File: rtl/pcs_tx.sv
// 100BASE-X style transmit PCS: samples MII nibbles once every five clocks,
// frames them with J/K ... T/R and serialises 5-bit code groups MSB first.
module pcs_tx
    import pcs_tx_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NIBBLE_W-1:0] txd,
    input  logic                tx_en,
    input  logic                tx_er,
    output logic                tx_ce,
    output logic                tx_data
);

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               tx_ce_q, tx_ce_d;
    pcs_state_e         state_q, state_d;
    code_t              sr_q, sr_d;
    logic               tx_data_q, tx_data_d;
    code_t              data_code_c;
    code_t              group_c;
    mii_tx_t            mii_c;

    assign mii_c = '{en: tx_en, er: tx_er, d: txd};

    encode_4b5b u_encode (
        .nibble_i (mii_c.d),
        .code_o   (data_code_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; transitions happen only on consume strobes.
    always_comb begin
        state_d = state_q;
        if (tx_ce_q) begin
            case (state_q)
                IDLE:    if (mii_c.en) state_d = START_K;
                START_K: state_d = DATA;
                DATA:    if (!mii_c.en) state_d = END_R;
                END_R:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Code group selected for the current sample.
    always_comb begin
        group_c = CODE_I;
        case (state_q)
            IDLE:    group_c = mii_c.en ? CODE_J : CODE_I;
            START_K: group_c = CODE_K;
            DATA: begin
                if (!mii_c.en) begin
                    group_c = CODE_T;
                end else if (mii_c.er) begin
                    group_c = CODE_H;
                end else begin
                    group_c = data_code_c;
                end
            end
            END_R:   group_c = CODE_R;
            default: group_c = CODE_I;
        endcase
    end

    // Phase counter, strobe and serialiser; the strobe is registered so it
    // lines up with phase 4, and ones are shifted in behind each group.
    always_comb begin
        phase_d   = (phase_q == PHASE_LAST) ? '0 : phase_q + PHASE_W'(1);
        tx_ce_d   = (phase_d == PHASE_LAST);
        sr_d      = tx_ce_q ? group_c : {sr_q[CODE_W-2:0], 1'b1};
        tx_data_d = sr_q[CODE_W-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q   <= '0;
            tx_ce_q   <= 1'b0;
            sr_q      <= CODE_I;
            tx_data_q <= 1'b1;
        end else begin
            phase_q   <= phase_d;
            tx_ce_q   <= tx_ce_d;
            sr_q      <= sr_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign tx_ce   = tx_ce_q;
    assign tx_data = tx_data_q;

endmodule

// File: tb/tb_pcs_tx.sv
// Self-checking bench for pcs_tx: directed framing scenarios plus randomised
// frames compared against a code-group queue model.
module tb_pcs_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] txd;
    logic       tx_en;
    logic       tx_er;
    logic       tx_ce;
    logic       tx_data;

    int checks = 0;
    int errors = 0;

    always #4 clk = ~clk;

    pcs_tx dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .txd     (txd),
        .tx_en   (tx_en),
        .tx_er   (tx_er),
        .tx_ce   (tx_ce),
        .tx_data (tx_data)
    );

    logic [4:0]  dtab [16];
    logic [4:0]  forced [$];
    bit          bitq [$];
    bit          in_frame;
    int          phase_m;
    bit          ce_now;
    logic [39:0] cap;

    task automatic chk(input string tag, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Reference: pick the code group for one sample and queue its bits.
    task automatic model_sample(input logic en, input logic er, input logic [3:0] d);
        logic [4:0] g;
        if (forced.size() > 0) begin
            g = forced.pop_front();
        end else if (!in_frame) begin
            if (en) begin
                g = 5'b11000;
                forced.push_back(5'b10001);
                in_frame = 1'b1;
            end else begin
                g = 5'b11111;
            end
        end else if (!en) begin
            g = 5'b01101;
            forced.push_back(5'b00111);
            in_frame = 1'b0;
        end else begin
            g = er ? 5'b00100 : dtab[d];
        end
        for (int i = 4; i >= 0; i--) bitq.push_back(g[i]);
    endtask

    task automatic tick();
        logic exp_d;
        if (rst_n === 1'b1 && ce_now) model_sample(tx_en, tx_er, txd);
        @(posedge clk);
        #1;
        if (rst_n !== 1'b1) begin
            bitq.delete();
            repeat (5) bitq.push_back(1'b1);
            forced.delete();
            in_frame = 1'b0;
            phase_m  = 0;
            ce_now   = 1'b0;
            exp_d    = 1'b1;
        end else begin
            phase_m = (phase_m + 1) % 5;
            ce_now  = (phase_m == 4);
            if (bitq.size() > 0) exp_d = bitq.pop_front();
            else                 exp_d = 1'bx;
        end
        chk("tx_ce", 40'(tx_ce), 40'(ce_now));
        chk("tx_data", 40'(tx_data), 40'(exp_d));
        cap = {cap[38:0], tx_data};
    endtask

    // Present one sample on the next consume edge; junk on the other edges.
    task automatic slot(input logic en, input logic er, input logic [3:0] d);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 6 && !done; n++) begin
            if (ce_now) begin
                tx_en = en; tx_er = er; txd = d;
                done  = 1'b1;
            end else begin
                tx_en = 1'($urandom); tx_er = 1'($urandom); txd = 4'($urandom);
            end
            tick();
        end
        if (!done) begin
            checks++;
            errors++;
            $error("FAIL slot_timeout observed=no_strobe expected=strobe");
        end
    endtask

    initial begin
        dtab = '{5'b11110, 5'b01001, 5'b10100, 5'b10101, 5'b01010, 5'b01011, 5'b01110, 5'b01111,
                 5'b10010, 5'b10011, 5'b10110, 5'b10111, 5'b11010, 5'b11011, 5'b11100, 5'b11101};
        rst_n = 1'b0; tx_en = 1'b0; tx_er = 1'b0; txd = 4'h0;
        cap = '1; ce_now = 1'b0; phase_m = 0; in_frame = 1'b0;

        // Reset then idle
        repeat (3) tick();
        chk("rst_tx_data", 40'(tx_data), 40'(1'b1));
        chk("rst_tx_ce", 40'(tx_ce), 40'(1'b0));
        rst_n = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            tx_en = 1'b0; tx_er = 1'($urandom); txd = 4'($urandom);
            tick();
            chk("idle_data", 40'(tx_data), 40'(1'b1));
            chk("idle_ce", 40'(tx_ce), 40'((c % 5) == 4));
        end

        // Basic frame 5,5,D,0,F
        slot(1, 0, 4'h5); slot(1, 0, 4'h5); slot(1, 0, 4'hD); slot(1, 0, 4'h0);
        slot(1, 0, 4'hF); slot(0, 0, 4'h0); slot(0, 0, 4'h0); slot(0, 0, 4'h0);
        slot(0, 0, 4'h0);
        chk("frame_stream", cap, 40'b11000_10001_11011_11110_11101_01101_00111_11111);

        // Error nibble mid-frame
        slot(1, 0, 4'h0); slot(1, 0, 4'h0); slot(1, 0, 4'h1); slot(1, 1, 4'h3);
        slot(1, 0, 4'h2);
        chk("err_h_group", 40'(cap[4:0]), 40'(5'b00100));
        slot(0, 0, 4'h0);
        chk("err_continue", 40'(cap[4:0]), 40'(5'b10100));
        slot(0, 0, 4'h0); slot(0, 0, 4'h0);

        // Back-to-back frames
        slot(1, 0, 4'h0); slot(1, 0, 4'h0); slot(1, 0, 4'h7); slot(0, 0, 4'h0);
        slot(1, 0, 4'h4); slot(1, 0, 4'h6); slot(1, 0, 4'h8); slot(1, 0, 4'h9);
        chk("b2b_t_r_j_k", 40'(cap[19:0]), 40'(20'b01101_00111_11000_10001));
        slot(0, 0, 4'h0); slot(0, 0, 4'h0); slot(0, 0, 4'h0);

        // Exhaustive data map
        slot(1, 0, 4'h0); slot(1, 0, 4'h0);
        for (int n = 0; n < 16; n++) begin
            slot(1, 0, 4'(n));
            if (n > 0) chk($sformatf("map_%0h", n - 1), 40'(cap[4:0]), 40'(dtab[n - 1]));
        end
        slot(0, 0, 4'h0);
        chk("map_f", 40'(cap[4:0]), 40'(dtab[15]));
        slot(0, 0, 4'h0); slot(0, 0, 4'h0);

        // Reset in the middle of a data group
        slot(1, 0, 4'h0); slot(1, 0, 4'h0); slot(1, 0, 4'hA); slot(1, 0, 4'hB);
        tick(); tick();
        rst_n = 1'b0;
        tick();
        chk("mrst_data", 40'(tx_data), 40'(1'b1));
        chk("mrst_ce", 40'(tx_ce), 40'(1'b0));
        tick();
        rst_n = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tx_en = 1'b1; tx_er = 1'b0; txd = 4'($urandom);
            tick();
            chk("mrst_resume_ce", 40'(tx_ce), 40'(c == 4 || c == 9));
            if (c <= 5) chk("mrst_idle_bits", 40'(tx_data), 40'(1'b1));
        end

        // Randomised traffic
        for (int s = 0; s < 300; s++) begin
            slot(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) == 0), 4'($urandom));
        end
        repeat (4) slot(0, 0, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
